// File: rtl/sdram_burst_arb_if.sv
// sdram_burst_arb_if
//   Bundles the two client burst ports and the SDRAM controller burst ports
//   that sdram_burst_arb sits between.
//   master : arbiter view (drives controller requests and client returns)
//   slave  : environment view (clients plus controller)
//   Client signals : cN_req/we/len/addr/wdata in, cN_valid/rdata/finish out
//   Controller     : wr_burst_* and rd_burst_* request/data/finish
interface sdram_burst_arb_if #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DQ_WIDTH    = 16,
  parameter int BURST_WIDTH = 9
);
  logic                   c0_req,    c1_req;
  logic                   c0_we,     c1_we;
  logic [BURST_WIDTH-1:0] c0_len,    c1_len;
  logic [ADDR_WIDTH-1:0]  c0_addr,   c1_addr;
  logic [DQ_WIDTH-1:0]    c0_wdata,  c1_wdata;
  logic                   c0_valid,  c1_valid;
  logic [DQ_WIDTH-1:0]    c0_rdata,  c1_rdata;
  logic                   c0_finish, c1_finish;

  logic                   wr_burst_req;
  logic [BURST_WIDTH-1:0] wr_burst_len;
  logic [ADDR_WIDTH-1:0]  wr_burst_addr;
  logic [DQ_WIDTH-1:0]    wr_burst_data;
  logic                   wr_burst_data_req;
  logic                   wr_burst_finish;
  logic                   rd_burst_req;
  logic [BURST_WIDTH-1:0] rd_burst_len;
  logic [ADDR_WIDTH-1:0]  rd_burst_addr;
  logic [DQ_WIDTH-1:0]    rd_burst_data;
  logic                   rd_burst_data_valid;
  logic                   rd_burst_finish;

  modport master (
    input  c0_req, c1_req, c0_we, c1_we, c0_len, c1_len,
           c0_addr, c1_addr, c0_wdata, c1_wdata,
    output c0_valid, c1_valid, c0_rdata, c1_rdata, c0_finish, c1_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data, rd_burst_data_valid, rd_burst_finish
  );

  modport slave (
    output c0_req, c1_req, c0_we, c1_we, c0_len, c1_len,
           c0_addr, c1_addr, c0_wdata, c1_wdata,
    input  c0_valid, c1_valid, c0_rdata, c1_rdata, c0_finish, c1_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data, rd_burst_data_valid, rd_burst_finish
  );
endinterface

// File: rtl/sdram_burst_arb.sv
// sdram_burst_arb
//   Two-client round-robin arbiter in front of the SDRAM burst controller.
//   One client at a time is granted; its latched request (we/len/addr) is
//   forwarded to the controller's write or read burst port, and data/valid/
//   finish are routed combinationally between that client and the controller.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus       : sdram_burst_arb_if.master (client + controller signals)
//     busy      : a burst is granted (BUSY state)
//     grant     : index of the granted client, meaningful while busy
//     wdog_err  : sticky watchdog flag
//   Optional: define SDRAM_ARB_WDOG_EN to enable the BUSY watchdog
//   (WDOG_CYCLES cycles); otherwise wdog_err is tied to 0.

// Per-client return path: valid and finish only reach the owning client.
module sdram_arb_client (
  input  logic owned,
  input  logic active,
  input  logic we,
  input  logic wr_data_req,
  input  logic rd_data_valid,
  input  logic fin_evt,
  output logic valid,
  output logic finish
);
  assign valid  = owned & active & (we ? wr_data_req : rd_data_valid);
  assign finish = owned & fin_evt;
endmodule

module sdram_burst_arb #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DQ_WIDTH    = 16,
  parameter int BURST_WIDTH = 9,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  sdram_burst_arb_if.master bus,
  output logic              busy,
  output logic              grant,
  output logic              wdog_err
);
  localparam int NUM_CLIENTS = 2;

  typedef struct packed {
    logic                   we;
    logic [BURST_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0]  addr;
  } burst_req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;

  burst_req_t [NUM_CLIENTS-1:0]               c_info;
  logic       [NUM_CLIENTS-1:0]               c_req;
  logic       [NUM_CLIENTS-1:0][DQ_WIDTH-1:0] c_wdata;
  logic       [NUM_CLIENTS-1:0]               c_valid;
  logic       [NUM_CLIENTS-1:0]               c_finish;

  burst_req_t lat_q;
  logic       grant_q;
  logic       prio_q;     // client that wins a tie
  logic       wr_req_q;
  logic       rd_req_q;
  logic       fin_zl_q;   // finish pulse for a zero-length burst, shown in RELEASE

  logic       any_req;
  logic       pick;
  logic       zlen;
  logic       ctrl_fin;
  logic       burst_done;
  logic       fin_evt;

  assign c_req   = {bus.c1_req, bus.c0_req};
  assign c_info  = {{bus.c1_we, bus.c1_len, bus.c1_addr},
                    {bus.c0_we, bus.c0_len, bus.c0_addr}};
  assign c_wdata = {bus.c1_wdata, bus.c0_wdata};

  // arbitration
  assign any_req = |c_req;
  always_comb begin
    pick = 1'b0;
    if (&c_req) pick = prio_q;
    else        pick = c_req[1];
  end

  assign zlen = (lat_q.len == '0);
  // only the finish of the latched direction counts
  assign ctrl_fin   = lat_q.we ? bus.wr_burst_finish : bus.rd_burst_finish;
  assign burst_done = (state_q == ST_BUSY) && (zlen || ctrl_fin);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (any_req)    state_d = ST_BUSY;
      ST_BUSY:    if (burst_done) state_d = ST_RELEASE;
      ST_RELEASE:                 state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy              = (state_q == ST_BUSY);
    // a zero-length burst never reaches the controller, so its finish
    // comes from fin_zl_q instead of the controller input
    fin_evt           = (busy && !zlen && ctrl_fin) || fin_zl_q;
    bus.wr_burst_data = c_wdata[grant_q];
  end

  // latched request, controller request levels, round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_q    <= '0;
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      fin_zl_q <= 1'b0;
    end else begin
      fin_zl_q <= (state_q == ST_BUSY) && zlen;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q  <= pick;
            lat_q    <= c_info[pick];
            wr_req_q <=  c_info[pick].we && (c_info[pick].len != '0);
            rd_req_q <= !c_info[pick].we && (c_info[pick].len != '0);
          end
        end
        ST_BUSY: begin
          if (burst_done) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            prio_q   <= ~grant_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant             = grant_q;
  assign bus.wr_burst_req  = wr_req_q;
  assign bus.wr_burst_len  = lat_q.len;
  assign bus.wr_burst_addr = lat_q.addr;
  assign bus.rd_burst_req  = rd_req_q;
  assign bus.rd_burst_len  = lat_q.len;
  assign bus.rd_burst_addr = lat_q.addr;

  // per-client return paths
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    sdram_arb_client u_client (
      .owned         (grant_q == 1'(i)),
      .active        (busy),
      .we            (lat_q.we),
      .wr_data_req   (bus.wr_burst_data_req),
      .rd_data_valid (bus.rd_burst_data_valid),
      .fin_evt       (fin_evt),
      .valid         (c_valid[i]),
      .finish        (c_finish[i])
    );
  end

  assign bus.c0_valid  = c_valid[0];
  assign bus.c1_valid  = c_valid[1];
  assign bus.c0_finish = c_finish[0];
  assign bus.c1_finish = c_finish[1];
  assign bus.c0_rdata  = bus.rd_burst_data;
  assign bus.c1_rdata  = bus.rd_burst_data;

`ifdef SDRAM_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wdog_q;

  // counts BUSY cycles of the current burst; saturates, never aborts it
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wdog_q   <= 1'b0;
    end else if (state_q == ST_IDLE && any_req) begin
      wd_cnt_q <= '0;
    end else if (state_q == ST_BUSY && wd_cnt_q != WD_MAX) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_MAX - 1'b1) wdog_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_q;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES == 0);
  assign wdog_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_burst_arb.sv
module tb_sdram_burst_arb;
  localparam int AW = 24, DW = 16, BW = 9, WD = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy, grant, wdog_err;
  always #5 clk = ~clk;

  sdram_burst_arb_if #(.ADDR_WIDTH(AW), .DQ_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  sdram_burst_arb #(.ADDR_WIDTH(AW), .DQ_WIDTH(DW), .BURST_WIDTH(BW),
                    .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .grant(grant), .wdog_err(wdog_err)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic       c0_req, c1_req, c0_we, c1_we;
    logic       wdreq, wfin, rvalid, rfin;
    logic [7:0] exp;  // {busy, grant, wr_req, rd_req, c0_valid, c1_valid, c0_fin, c1_fin}
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c0_req = 0; bus.c1_req = 0; bus.c0_we = 0; bus.c1_we = 0;
    bus.c0_len = '0; bus.c1_len = '0; bus.c0_addr = '0; bus.c1_addr = '0;
    bus.c0_wdata = '0; bus.c1_wdata = '0;
    bus.wr_burst_data_req = 0; bus.wr_burst_finish = 0;
    bus.rd_burst_data = '0; bus.rd_burst_data_valid = 0; bus.rd_burst_finish = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  function automatic logic [7:0] snap();
    return {busy, grant, bus.wr_burst_req, bus.rd_burst_req,
            bus.c0_valid, bus.c1_valid, bus.c0_finish, bus.c1_finish};
  endfunction

  // waits for the next grant (bounded), checks winner and the gap, then finishes it
  task automatic alt_burst(input logic exp_g, input bit chk_gap);
    int n = 0;
    while (!busy && n < 8) begin
      tick();
      n++;
    end
    chk("alt_busy", 32'(busy), 1);
    chk("alt_grant", 32'(grant), 32'(exp_g));
    if (chk_gap) chk("alt_gap", n, 2);
    bus.wr_burst_finish = 1;
    #1;
    chk("alt_fin", 32'(exp_g ? bus.c1_finish : bus.c0_finish), 1);
    tick();
    bus.wr_burst_finish = 0;
  endtask

  initial begin
    // {c0_req,c1_req,c0_we,c1_we, wdreq,wfin,rvalid,rfin, exp}
    vecs[0]  = '{0,0,0,0, 0,0,0,0, 8'b0000_0000};
    vecs[1]  = '{0,1,0,0, 0,0,0,0, 8'b0000_0000};  // c1 read request seen
    vecs[2]  = '{0,1,0,0, 0,0,1,0, 8'b1101_0100};  // granted, rdata valid
    vecs[3]  = '{0,1,0,0, 0,0,0,0, 8'b1101_0000};
    vecs[4]  = '{0,1,0,0, 0,0,1,1, 8'b1101_0101};  // last beat + finish
    vecs[5]  = '{1,1,1,0, 0,0,0,0, 8'b0100_0000};  // RELEASE ignores reqs
    vecs[6]  = '{1,1,1,0, 0,0,0,0, 8'b0100_0000};  // IDLE, tie -> c0
    vecs[7]  = '{1,1,1,0, 1,0,0,1, 8'b1010_1000};  // rd finish ignored on write
    vecs[8]  = '{1,1,1,0, 1,1,0,0, 8'b1010_1010};
    vecs[9]  = '{1,1,1,0, 0,0,0,0, 8'b0000_0000};  // RELEASE
    vecs[10] = '{1,1,1,0, 0,0,0,0, 8'b0000_0000};  // IDLE, tie -> c1
    vecs[11] = '{1,1,1,0, 0,0,0,0, 8'b1101_0000};
    vecs[12] = '{1,1,1,0, 1,0,1,0, 8'b1101_0100};  // wr data req ignored on read

    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_reqs", 32'({bus.wr_burst_req, bus.rd_burst_req}), 0);
    chk("rst_len_addr", 32'({bus.wr_burst_len, bus.wr_burst_addr}), 0);
    chk("rst_wdog", 32'(wdog_err), 0);

    // table-driven sequence
    bus.c0_len = 9'd2; bus.c1_len = 9'd2;
    for (int i = 0; i < 13; i++) begin
      bus.c0_req = vecs[i].c0_req; bus.c1_req = vecs[i].c1_req;
      bus.c0_we = vecs[i].c0_we; bus.c1_we = vecs[i].c1_we;
      bus.wr_burst_data_req = vecs[i].wdreq; bus.wr_burst_finish = vecs[i].wfin;
      bus.rd_burst_data_valid = vecs[i].rvalid; bus.rd_burst_finish = vecs[i].rfin;
      #1;
      chk($sformatf("vec%0d", i), 32'(snap()), 32'(vecs[i].exp));
      tick();
    end

    // c0 write, len 8, addr 0x100
    do_reset();
    bus.c0_req = 1; bus.c0_we = 1; bus.c0_len = 9'd8; bus.c0_addr = 24'h000100;
    #1;
    chk("w8_req_lat0", 32'(bus.wr_burst_req), 0);
    tick();
    chk("w8_req", 32'({busy, grant, bus.wr_burst_req, bus.rd_burst_req}), 32'b1010);
    chk("w8_len", 32'(bus.wr_burst_len), 8);
    chk("w8_addr", 32'(bus.wr_burst_addr), 32'h100);
    for (int i = 0; i < 8; i++) begin
      bus.wr_burst_data_req = 1;
      bus.c0_wdata = 16'h3000 + 16'(i);
      #1;
      chk($sformatf("w8_beat%0d", i),
          32'({bus.c0_valid, bus.c1_valid, bus.wr_burst_data}),
          32'({2'b10, 16'h3000 + 16'(i)}));
      tick();
      bus.wr_burst_data_req = 0;
      #1;
      chk("w8_gap_valid", 32'(bus.c0_valid), 0);
    end
    bus.wr_burst_finish = 1;
    #1;
    chk("w8_fin", 32'({bus.c0_finish, bus.c1_finish}), 32'b10);
    tick();
    bus.wr_burst_finish = 0; bus.c0_req = 0;
    #1;
    chk("w8_release", 32'({busy, bus.wr_burst_req, bus.c0_finish}), 0);
    tick();
    chk("w8_idle", 32'(busy), 0);

    // both requesting from reset: c0, c1, c0
    do_reset();
    bus.c0_req = 1; bus.c1_req = 1; bus.c0_we = 1; bus.c1_we = 1;
    bus.c0_len = 9'd1; bus.c1_len = 9'd1;
    alt_burst(1'b0, 1'b0);
    alt_burst(1'b1, 1'b1);
    alt_burst(1'b0, 1'b1);

    // c1 read, len 4
    do_reset();
    bus.c1_req = 1; bus.c1_we = 0; bus.c1_len = 9'd4; bus.c1_addr = 24'h012345;
    tick();
    chk("r4_req", 32'({bus.rd_burst_req, bus.wr_burst_req, grant}), 32'b101);
    chk("r4_addr", 32'(bus.rd_burst_addr), 32'h012345);
    for (int i = 0; i < 4; i++) begin
      bus.rd_burst_data_valid = 1;
      bus.rd_burst_data = 16'hA5A0 + 16'(i);
      bus.rd_burst_finish = (i == 3);
      #1;
      chk($sformatf("r4_beat%0d", i),
          32'({bus.c1_valid, bus.c0_valid, bus.wr_burst_req, bus.c1_rdata}),
          32'({3'b100, 16'hA5A0 + 16'(i)}));
      if (i == 3) chk("r4_fin", 32'(bus.c1_finish), 1);
      tick();
    end
    bus.rd_burst_data_valid = 0; bus.rd_burst_finish = 0; bus.c1_req = 0;
    #1;
    chk("r4_done", 32'({busy, bus.rd_burst_req}), 0);

    // zero length on c0
    do_reset();
    bus.c0_req = 1; bus.c0_we = 1; bus.c0_len = 9'd0;
    #1;
    chk("z_c0", 32'(snap()), 0);
    tick();
    chk("z_c1", 32'(snap()), 32'b1000_0000);
    tick();
    bus.c0_req = 0;
    #1;
    chk("z_c2", 32'(snap()), 32'b0000_0010);
    tick();
    chk("z_c3", 32'(snap()), 0);
    tick();
    chk("z_c4", 32'(snap()), 0);

    // reset mid-burst at beat 3 of 8, then a c1-only request
    do_reset();
    bus.c0_req = 1; bus.c0_we = 1; bus.c0_len = 9'd8; bus.c0_addr = 24'h000200;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.wr_burst_data_req = 1;
      tick();
    end
    bus.wr_burst_data_req = 0;
    rst = 1;
    tick();
    chk("mr_state", 32'({bus.wr_burst_req, busy, wdog_err}), 0);
    rst = 0;
    bus.c0_req = 0;
    bus.c1_req = 1; bus.c1_we = 1; bus.c1_len = 9'd2; bus.c1_addr = 24'h000300;
    tick();
    chk("mr_c1", 32'({busy, grant, bus.wr_burst_req}), 32'b111);
    chk("mr_addr", 32'(bus.wr_burst_addr), 32'h300);
    bus.wr_burst_finish = 1;
    #1;
    chk("mr_fin", 32'(bus.c1_finish), 1);
    tick();
    bus.wr_burst_finish = 0; bus.c1_req = 0;

`ifdef SDRAM_ARB_WDOG_EN
    do_reset();
    bus.c0_req = 1; bus.c0_we = 1; bus.c0_len = 9'd4;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("wd_15", 32'(wdog_err), 0);
    tick();
    chk("wd_16", 32'(wdog_err), 1);
    bus.wr_burst_finish = 1;
    #1;
    chk("wd_fin", 32'(bus.c0_finish), 1);
    tick();
    bus.wr_burst_finish = 0; bus.c0_req = 0;
    tick();
    chk("wd_sticky", 32'({wdog_err, busy}), 32'b10);
`else
    chk("wd_off", 32'(wdog_err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
